// File: rtl/lsu_pipe.sv
// Byte-lane load/store unit with a one-entry response slot.
// Responses return one cycle after accept; debug port reads memory directly.
module lsu_pipe #(
  parameter int LANES  = 4,
  parameter int ADDR_W = 8,
  parameter int ERR_W  = 16,
  localparam int DATA_W = 8 * LANES,
  localparam int OFS_W  = $clog2(LANES)
) (
  input  logic                    sysclk,
  input  logic                    rstd,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [1:0]              req_size,
  input  logic                    req_signed,
  input  logic [ADDR_W+OFS_W-1:0] req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_err,
  output logic [ERR_W-1:0]        err_cnt,
  input  logic [ADDR_W-1:0]       dbg_addr,
  output logic [DATA_W-1:0]       dbg_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic [ADDR_W-1:0] idx;
  logic [OFS_W-1:0]  ofs;
  logic [OFS_W+2:0]  sh;
  logic              accept;
  logic              req_err;
  logic [LANES-1:0]  be;
  logic [DATA_W-1:0] wsh;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_sh;
  logic [DATA_W-1:0] ld_data;

  assign idx = req_addr[ADDR_W+OFS_W-1:OFS_W];
  assign ofs = req_addr[OFS_W-1:0];
  assign sh  = {ofs, 3'b000};

  assign req_ready = !rsp_valid || rsp_ready;
  // reset blocks accepts so a store cannot land while rstd is high
  assign accept    = req_valid && req_ready && !rstd;

  always_comb begin
    req_err = 1'b0;
    unique case (req_size)
      2'd0: req_err = 1'b0;
      2'd1: req_err = ofs[0];
      2'd2: req_err = (ofs != '0);
      default: req_err = 1'b1;
    endcase
  end

  always_comb begin
    be = '1;
    unique case (req_size)
      2'd0: be = LANES'(1) << ofs;
      2'd1: be = LANES'(3) << ofs;
      default: be = '1;
    endcase
  end

  assign wsh     = req_wdata << sh;
  assign rd_word = mem[idx];
  assign rd_sh   = rd_word >> sh;

  always_comb begin
    ld_data = rd_word;
    unique case (req_size)
      2'd0: begin
        ld_data = rd_sh & DATA_W'(8'hff);
        if (req_signed && rd_sh[7]) ld_data = ld_data | ~DATA_W'(8'hff);
      end
      2'd1: begin
        ld_data = rd_sh & DATA_W'(16'hffff);
        if (req_signed && rd_sh[15]) ld_data = ld_data | ~DATA_W'(16'hffff);
      end
      default: ld_data = rd_word;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (accept && req_we && !req_err) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wsh[8*i +: 8];
      end
    end
  end

  always_ff @(posedge sysclk or posedge rstd) begin
    if (rstd) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      if (accept) begin
        rsp_valid <= 1'b1;
        rsp_err   <= req_err;
        rsp_data  <= (req_err || req_we) ? '0 : ld_data;
        if (req_err && (err_cnt != '1)) err_cnt <= err_cnt + ERR_W'(1);
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  assign dbg_data = mem[dbg_addr];

endmodule
